popcount_accum: RTL and testbench
=================================

// Module: popcount_accum
// PURPOSE
//  Parametrised successor to the 5:3 compressor: pipelined N-bit popcount built from a 5:3 compressor
//  tree, followed by a group accumulator. Counts ones (or XNOR matches) per beat and sums them over a
//  group terminated by in_last. Sits between binary activation/weight fetch and the output/requant stage.
// PARAMETERS
//  N_IN     32  bits per input beat (>=5)
//  ACC_W    16  accumulator/result width; saturates at 2**ACC_W-1
//  BEAT_W   10  beats-per-group counter width; saturates at 2**BEAT_W-1
//  XNOR_EN  1   1: count ~(in_data ^ in_wgt) when in_xnor=1; 0: in_xnor, in_wgt ignored
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       input beat valid
//  in_ready   out  1       block can accept a beat this cycle
//  in_data    in   N_IN    activation bits
//  in_wgt     in   N_IN    weight bits (XNOR mode only)
//  in_xnor    in   1       per-beat mode: 0 popcount(in_data), 1 popcount(~(in_data^in_wgt))
//  in_last    in   1       final beat of current group
//  out_valid  out  1       result valid, held until out_ready
//  out_ready  in   1       downstream accepts result
//  out_count  out  ACC_W   group sum of per-beat counts (saturated)
//  out_beats  out  BEAT_W  beats in group (saturated)
//  out_sat    out  1       sticky: accumulator or beat counter saturated within this group
// BEHAVIOUR
//  - Reset (async assert, sync-released use): out_valid=0, out_count=0, out_beats=0, out_sat=0,
//    S1 valid=0, accumulator=0, beat counter=0, sat flag=0. in_ready=1 once rst_n high.
//  - Global enable en = !out_valid | out_ready; in_ready = en. All pipeline regs update only when en.
//  - Beat accepted on in_valid & in_ready. Per-beat count CNT_W=$clog2(N_IN+1) bits, exact, no loss.
//  - S1 (cycle t+1): registers {s1_valid, s1_cnt, s1_last}. Tree is combinational before S1.
//  - S2 (cycle t+2): if s1_valid & !s1_last: acc += s1_cnt (sat), beats += 1 (sat).
//    if s1_valid & s1_last: out_count = sat(acc+s1_cnt), out_beats = sat(beats+1), out_sat = sticky|new
//    sat; out_valid=1; acc, beats, sticky cleared same edge. Latency last-beat accept -> out_valid: 2 clk.
//  - If en and out_valid & out_ready and no new result: out_valid falls. If new result arrives same
//    edge as out_ready: output regs reload, out_valid stays 1 (back-to-back results, no bubble).
//  - Stall (out_valid & !out_ready): in_ready=0, S1 and accumulator frozen; outputs stable.
//  - Saturation: acc+cnt > 2**ACC_W-1 -> clamp, set sticky; beats likewise for BEAT_W.
//  - Single-beat group (in_last on first beat): out_count = that beat's count, out_beats=1.
//  - Empty beat (in_valid=0): no state change in S1 valid path; bubbles do not affect acc.
//  - XNOR_EN=0: in_xnor treated as 0.
//  - rst_n low mid-group or mid-stall: partial sums and pending result discarded, all to reset values.
// STRUCTURE
//  - Package npu_popcnt_pkg: function cnt_w(n)=$clog2(n+1); saturating-add function sat_add(a,b,w).
//  - Sub-module popcnt_tree #(N_IN): combinational compressor tree of 5:3 cells (pad to multiple of 5
//    with zeros), final carry-propagate add; output CNT_W bits. Instantiated once.
//  - Top: mode mux, S1 register, accumulator/beat/sticky regs, output regs, enable logic.
// TESTING
//  1 Reset: rst_n=0 -> all outputs 0, in_ready=0->1 after release; no out_valid without input.
//  2 Single beat: in_data=32'hFFFF_FFFF,in_last=1,in_xnor=0 -> 2 clk later out_count=32,out_beats=1,sat=0.
//  3 XNOR group: beats (data=32'hF0F0_F0F0,wgt=32'hF0F0_F0F0),(data=0,wgt=32'hFFFF_FFFF,last) ->
//    out_count=32, out_beats=2.
//  4 Backpressure: out_ready=0 with result pending, in_valid=1 -> in_ready=0, outputs stable 10 clk;
//    out_ready=1 -> next group result follows with no lost beat; back-to-back results, no bubble.
//  5 Saturation: ACC_W=8, 9 beats of 32'hFFFF_FFFF, last on 9th -> out_count=255, out_sat=1;
//    next group of 1 beat 32'h1 -> out_count=1, out_sat=0.
//  6 Reset mid-group: 3 beats accepted, no last, rst_n pulse -> then 1-beat group 32'h3 gives
//    out_count=2, out_beats=1 (no carry-over).

Source files
------------

// File: rtl/npu_popcnt_pkg.sv
// Shared helpers for the popcount accumulator: count width and saturating add.
package npu_popcnt_pkg;

  typedef enum logic {
    MODE_POP  = 1'b0,
    MODE_XNOR = 1'b1
  } mode_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Operands are assumed narrower than 63 bits so the raw sum cannot wrap.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] max_v;
    logic [63:0] sum;
    max_v = (64'd1 << w) - 64'd1;
    sum   = a + b;
    return (sum > max_v) ? max_v : sum;
  endfunction

  function automatic logic sat_ovf(input logic [63:0] a, input logic [63:0] b,
                                   input int unsigned w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (a + b) > max_v;
  endfunction

endpackage

// File: rtl/popcnt_tree.sv
// Combinational N-bit popcount: a layer of 5:3 counters over zero-padded input,
// then a carry-propagate sum of the 3-bit cell counts.
module popcnt_tree
  import npu_popcnt_pkg::*;
#(
  parameter int unsigned N_IN = 32,
  localparam int unsigned CNT_W = cnt_w(N_IN)
) (
  input  logic [N_IN-1:0]  bits,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned N_CELL = (N_IN + 4) / 5;
  localparam int unsigned PAD_W  = N_CELL * 5;

  logic [PAD_W-1:0] padded;
  logic [2:0]       cell_sum [N_CELL];

  assign padded = PAD_W'(bits);

  for (genvar g = 0; g < N_CELL; g++) begin : g_cell
    logic [4:0] x;
    logic       s1, c1, c2;
    assign x  = padded[g*5 +: 5];
    // Two full adders; their carries share weight 2 and combine into bits 1..2.
    assign s1 = x[0] ^ x[1] ^ x[2];
    assign c1 = (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
    assign c2 = (s1 & x[3]) | (s1 & x[4]) | (x[3] & x[4]);
    assign cell_sum[g] = {c1 & c2, c1 ^ c2, s1 ^ x[3] ^ x[4]};
  end

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < N_CELL; i++) begin
      count = count + CNT_W'(cell_sum[i]);
    end
  end

endmodule

// File: rtl/popcount_accum.sv
// Pipelined popcount (or XNOR-match count) per beat, summed per group delimited by in_last,
// with saturating accumulator/beat counter and a held result handshake.
module popcount_accum
  import npu_popcnt_pkg::*;
#(
  parameter int unsigned N_IN    = 32,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned BEAT_W  = 10,
  parameter int unsigned XNOR_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  input  logic [N_IN-1:0]   in_wgt,
  input  logic              in_xnor,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_count,
  output logic [BEAT_W-1:0] out_beats,
  output logic              out_sat
);

  localparam int unsigned CNT_W = cnt_w(N_IN);

  mode_e             mode;
  logic [N_IN-1:0]   bits;
  logic [CNT_W-1:0]  beat_cnt;
  logic              en;
  logic              accept;

  logic              s1_valid;
  logic              s1_last;
  logic [CNT_W-1:0]  s1_cnt;

  logic [ACC_W-1:0]  acc;
  logic [BEAT_W-1:0] beats;
  logic              sticky;

  logic [ACC_W-1:0]  acc_sum;
  logic [BEAT_W-1:0] beats_sum;
  logic              new_sat;

  assign en       = !out_valid || out_ready;
  assign in_ready = rst_n && en;
  assign accept   = in_valid && in_ready;

  assign mode = ((XNOR_EN != 0) && in_xnor) ? MODE_XNOR : MODE_POP;
  assign bits = (mode == MODE_XNOR) ? ~(in_data ^ in_wgt) : in_data;

  popcnt_tree #(.N_IN(N_IN)) u_tree (
    .bits  (bits),
    .count (beat_cnt)
  );

  assign acc_sum   = ACC_W'(sat_add(64'(acc), 64'(s1_cnt), ACC_W));
  assign beats_sum = BEAT_W'(sat_add(64'(beats), 64'd1, BEAT_W));
  assign new_sat   = sticky
                   || sat_ovf(64'(acc), 64'(s1_cnt), ACC_W)
                   || sat_ovf(64'(beats), 64'd1, BEAT_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cnt   <= '0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      s1_cnt   <= beat_cnt;
      s1_last  <= in_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      beats  <= '0;
      sticky <= 1'b0;
    end else if (en && s1_valid) begin
      if (s1_last) begin
        acc    <= '0;
        beats  <= '0;
        sticky <= 1'b0;
      end else begin
        acc    <= acc_sum;
        beats  <= beats_sum;
        sticky <= new_sat;
      end
    end
  end

  // A new result landing on the same edge as out_ready simply reloads, keeping out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_count <= '0;
      out_beats <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      if (s1_valid && s1_last) begin
        out_valid <= 1'b1;
        out_count <= acc_sum;
        out_beats <= beats_sum;
        out_sat   <= new_sat;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_popcount_accum.sv
// Directed and randomized checks of popcount_accum against a group-sum reference model.
module tb_popcount_accum;

  localparam int unsigned N_IN   = 32;
  localparam int unsigned ACC_W  = 8;
  localparam int unsigned BEAT_W = 4;
  localparam int MAX_CNT  = (1 << ACC_W) - 1;
  localparam int MAX_BEAT = (1 << BEAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_data;
  logic [N_IN-1:0]   in_wgt;
  logic              in_xnor;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_count;
  logic [BEAT_W-1:0] out_beats;
  logic              out_sat;

  popcount_accum #(
    .N_IN    (N_IN),
    .ACC_W   (ACC_W),
    .BEAT_W  (BEAT_W),
    .XNOR_EN (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_wgt    (in_wgt),
    .in_xnor   (in_xnor),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_beats (out_beats),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int beats;
    bit sat;
  } res_t;

  res_t expq[$];
  int   g_sum   = 0;
  int   g_beats = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a group result is the clamped true sum of per-beat ones counts.
  task automatic model_beat();
    logic [31:0] b;
    res_t r;
    b = in_xnor ? ~(in_data ^ in_wgt) : in_data;
    g_sum   += $countones(b);
    g_beats += 1;
    if (in_last) begin
      r.cnt   = (g_sum > MAX_CNT) ? MAX_CNT : g_sum;
      r.beats = (g_beats > MAX_BEAT) ? MAX_BEAT : g_beats;
      r.sat   = (g_sum > MAX_CNT) || (g_beats > MAX_BEAT);
      expq.push_back(r);
      g_sum   = 0;
      g_beats = 0;
    end
  endtask

  // One clock: sample at mid-cycle, score handshakes, advance to just after the next edge.
  task automatic step();
    res_t e;
    #4;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_result", {31'b0, out_valid}, 32'd0);
      end else begin
        e = expq.pop_front();
        check("out_count", 32'(out_count), e.cnt);
        check("out_beats", 32'(out_beats), e.beats);
        check("out_sat", {31'b0, out_sat}, {31'b0, e.sat});
      end
    end
    if (in_valid && in_ready) model_beat();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic [31:0] w, input logic x, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_wgt   = w;
    in_xnor  = x;
    in_last  = l;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && expq.size() > 0; i++) step();
    check("drain_queue_empty", expq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_out_count"}, 32'(out_count), 32'd0);
    check({tag, "_out_beats"}, 32'(out_beats), 32'd0);
    check({tag, "_out_sat"}, {31'b0, out_sat}, 32'd0);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_wgt = '0;
    in_xnor = 1'b0; in_last = 1'b0; out_ready = 1'b0;

    // Reset state, then idle with no spurious result.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    check("in_ready_after_release", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      idle();
      check("idle_no_valid", {31'b0, out_valid}, 32'd0);
    end

    // Single full beat: result exactly two edges after acceptance.
    beat(32'hFFFF_FFFF, '0, 1'b0, 1'b1);
    in_valid = 1'b0;
    check("latency_1clk", {31'b0, out_valid}, 32'd0);
    step();
    check("latency_2clk", {31'b0, out_valid}, 32'd1);
    check("single_count", 32'(out_count), 32'd32);
    check("single_beats", 32'(out_beats), 32'd1);
    out_ready = 1'b1;
    step();
    check("valid_falls", {31'b0, out_valid}, 32'd0);

    // XNOR group: all-match beat (32) plus all-mismatch beat (0).
    beat(32'hF0F0_F0F0, 32'hF0F0_F0F0, 1'b1, 1'b0);
    beat(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    drain();

    // Backpressure with a pending result, then back-to-back results.
    out_ready = 1'b0;
    beat(32'h0000_00FF, '0, 1'b0, 1'b1);
    beat(32'h0000_000F, '0, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = 32'h3; in_xnor = 1'b0; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_out_count", 32'(out_count), 32'd8);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("no_bubble", {31'b0, out_valid}, 32'd1);
      step();
    end
    drain();

    // Accumulator saturation, then a clean group with the sticky flag cleared.
    for (int i = 0; i < 9; i++) beat(32'hFFFF_FFFF, '0, 1'b0, (i == 8));
    beat(32'h0000_0001, '0, 1'b0, 1'b1);
    drain();
    // Beat-counter saturation on a long all-zero group.
    for (int i = 0; i < 20; i++) beat(32'h0, '0, 1'b0, (i == 19));
    drain();

    // Reset mid-group discards the partial sum.
    for (int i = 0; i < 3; i++) beat(32'h0000_00FF, '0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    g_sum = 0; g_beats = 0; expq.delete();
    @(posedge clk);
    #1;
    check_reset_outputs("midgroup_reset");
    rst_n = 1'b1;
    beat(32'h0000_0003, '0, 1'b0, 1'b1);
    idle();
    check("post_reset_count", 32'(out_count), 32'd2);
    check("post_reset_beats", 32'(out_beats), 32'd1);
    drain();

    // Randomized traffic with random backpressure and mixed modes.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = $urandom;
      in_wgt    = $urandom;
      in_xnor   = $urandom_range(1);
      in_last   = (i < 1500) ? ($urandom_range(4) == 0) : ($urandom_range(19) == 0);
      out_ready = ($urandom_range(2) != 0);
      #1;
      check("rand_in_ready", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      #1;
      step();
      #(-0);
    end
    in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) step();
    step();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
